// File: rtl/imem_load_arbiter_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package imem_load_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_HDR0,
        ST_HDR1,
        ST_DATA,
        ST_HOLD
    } ld_state_t;

    localparam int unsigned HDR_BYTES = 2;

endpackage

// File: rtl/imem_load_arbiter_byte_packer.sv
// Assembles four loader bytes little-endian into a 32-bit word; word_valid
// pulses for one cycle after the fourth byte is accepted.
module byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  idx;
    logic [23:0] acc;

    // The finished word lives in its own register so the next word can start
    // filling while the previous one is being written.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            idx        <= '0;
            acc        <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (byte_valid) begin
                unique case (idx)
                    2'd0: acc[7:0]   <= byte_data;
                    2'd1: acc[15:8]  <= byte_data;
                    2'd2: acc[23:16] <= byte_data;
                    2'd3: begin
                        word       <= {byte_data, acc};
                        word_valid <= 1'b1;
                    end
                    default: ;
                endcase
                idx <= idx + 2'd1;
            end
        end
    end

endmodule

// File: rtl/imem_load_arbiter.sv
// Arbitrates instruction memory between the CPU fetch port and a byte-stream
// program loader, holding the CPU in reset while a load is in progress.
module imem_load_arbiter
    import imem_load_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_req,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_we,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              load_done,
    output logic [ADDR_W-1:0] words_loaded
);

    localparam int unsigned HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    ld_state_t         state, state_next;
    logic [ADDR_W-1:0] count;
    logic [ADDR_W-1:0] ptr;
    logic [HC_W-1:0]   hold_cnt;
    logic [ADDR_W-1:0] hdr_count;
    logic              accept;
    logic              word_valid;
    logic              last_word;
    logic              hold_end;

    assign accept    = rx_valid && rx_ready;
    // HDR1 byte supplies the upper count bits; bits beyond ADDR_W fall off.
    assign hdr_count = ADDR_W'({rx_data, count[7:0]});
    assign last_word = word_valid && (ptr == count - 1'b1);
    assign hold_end  = (hold_cnt == HC_W'(HOLD_CYCLES - 1));

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (state != ST_DATA),
        .byte_valid (accept && (state == ST_DATA)),
        .byte_data  (rx_data),
        .word       (imem_wdata),
        .word_valid (word_valid)
    );

    always_comb begin
        state_next = state;
        rx_ready   = 1'b0;
        cpu_rst_n  = 1'b0;
        busy       = 1'b1;
        imem_addr  = ptr;
        imem_we    = 1'b0;
        unique case (state)
            ST_RUN: begin
                cpu_rst_n = 1'b1;
                busy      = 1'b0;
                imem_addr = cpu_addr;
                if (load_req) state_next = ST_HDR0;
            end
            ST_HDR0: begin
                rx_ready = 1'b1;
                if (accept) state_next = ST_HDR1;
            end
            ST_HDR1: begin
                rx_ready = 1'b1;
                if (accept) state_next = (hdr_count == '0) ? ST_HOLD : ST_DATA;
            end
            ST_DATA: begin
                rx_ready = 1'b1;
                imem_we  = word_valid;
                if (last_word) state_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (hold_end) state_next = ST_RUN;
            end
            default: state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_RUN;
            count        <= '0;
            ptr          <= '0;
            hold_cnt     <= '0;
            words_loaded <= '0;
            load_done    <= 1'b0;
        end else begin
            state     <= state_next;
            load_done <= (state == ST_HOLD) && hold_end;
            unique case (state)
                ST_HDR0: if (accept) count <= ADDR_W'(rx_data);
                ST_HDR1: begin
                    if (accept) begin
                        count <= hdr_count;
                        ptr   <= '0;
                        if (hdr_count == '0) words_loaded <= '0;
                    end
                end
                ST_DATA: begin
                    if (word_valid) ptr <= ptr + 1'b1;
                    if (last_word) words_loaded <= count;
                end
                ST_HOLD: hold_cnt <= hold_end ? '0 : hold_cnt + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_load_arbiter.sv
// Directed self-checking bench for imem_load_arbiter.
module tb_imem_load_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_req;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic [11:0] cpu_addr;
    logic [11:0] imem_addr;
    logic        imem_we;
    logic [31:0] imem_wdata;
    logic        cpu_rst_n;
    logic        busy;
    logic        load_done;
    logic [11:0] words_loaded;

    int total = 0;
    int bad   = 0;
    int held;
    int wes;

    always #5 clk = ~clk;

    imem_load_arbiter #(.ADDR_W(12), .HOLD_CYCLES(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .load_req     (load_req),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .cpu_addr     (cpu_addr),
        .imem_addr    (imem_addr),
        .imem_we      (imem_we),
        .imem_wdata   (imem_wdata),
        .cpu_rst_n    (cpu_rst_n),
        .busy         (busy),
        .load_done    (load_done),
        .words_loaded (words_loaded)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Counts cycles with the CPU held, bounded so a stuck FSM still ends.
    task automatic wait_release(output int h, output int w);
        h = 0;
        w = 0;
        for (int i = 0; i < 20 && cpu_rst_n !== 1'b1; i++) begin
            if (imem_we === 1'b1) w++;
            h++;
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        load_req = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        cpu_addr = 12'h000;
        idle(2);
        chk("rst_busy", busy, 0);
        chk("rst_cpu_rst_n", cpu_rst_n, 1);
        chk("rst_we", imem_we, 0);
        chk("rst_load_done", load_done, 0);
        chk("rst_words", words_loaded, 0);
        chk("rst_rx_ready", rx_ready, 0);
        rst = 1'b0;
        step();

        // Basic two-word load
        load_req = 1'b1;
        step();
        load_req = 1'b0;
        chk("l1_busy", busy, 1);
        chk("l1_rx_ready", rx_ready, 1);
        chk("l1_cpu_held", cpu_rst_n, 0);
        send(8'h02); send(8'h00);
        send(8'h13);
        chk("l1_no_we_b0", imem_we, 0);
        send(8'h05); send(8'h10); send(8'h00);
        chk("l1_w0_we", imem_we, 1);
        chk("l1_w0_addr", imem_addr, 12'h000);
        chk("l1_w0_data", imem_wdata, 32'h00100513);
        send(8'h73);
        chk("l1_we_single", imem_we, 0);
        send(8'h10); send(8'h00); send(8'hF0);
        chk("l1_w1_we", imem_we, 1);
        chk("l1_w1_addr", imem_addr, 12'h001);
        chk("l1_w1_data", imem_wdata, 32'hF0001073);
        step();
        wait_release(held, wes);
        chk("l1_hold_cycles", held, 4);
        chk("l1_hold_no_we", wes, 0);
        chk("l1_load_done", load_done, 1);
        chk("l1_words", words_loaded, 2);
        chk("l1_run_busy", busy, 0);
        step();
        chk("l1_done_pulse", load_done, 0);

        // Empty header
        load_req = 1'b1;
        step();
        load_req = 1'b0;
        send(8'h00); send(8'h00);
        wait_release(held, wes);
        chk("l0_hold_cycles", held, 4);
        chk("l0_no_we", wes, 0);
        chk("l0_load_done", load_done, 1);
        chk("l0_words", words_loaded, 0);

        // Three-cycle bubbles between every byte
        load_req = 1'b1;
        step();
        load_req = 1'b0;
        send(8'h02); idle(3); send(8'h00); idle(3);
        send(8'h13); idle(3); send(8'h05); idle(3); send(8'h10); idle(3);
        send(8'h00);
        chk("lg_w0_we", imem_we, 1);
        chk("lg_w0_addr", imem_addr, 12'h000);
        chk("lg_w0_data", imem_wdata, 32'h00100513);
        step();
        chk("lg_w0_once", imem_we, 0);
        idle(2);
        send(8'h73); idle(3); send(8'h10); idle(3); send(8'h00); idle(3);
        chk("lg_gap_no_we", imem_we, 0);
        send(8'hF0);
        chk("lg_w1_we", imem_we, 1);
        chk("lg_w1_addr", imem_addr, 12'h001);
        chk("lg_w1_data", imem_wdata, 32'hF0001073);
        step();
        wait_release(held, wes);
        chk("lg_hold_cycles", held, 4);
        chk("lg_words", words_loaded, 2);

        // Reset in the middle of the second word
        load_req = 1'b1;
        step();
        load_req = 1'b0;
        send(8'h02); send(8'h00);
        send(8'h13); send(8'h05); send(8'h10); send(8'h00);
        chk("lr_w0_we", imem_we, 1);
        chk("lr_w0_addr", imem_addr, 12'h000);
        send(8'h73); send(8'h10);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("lr_busy", busy, 0);
        chk("lr_cpu_rst_n", cpu_rst_n, 1);
        chk("lr_words", words_loaded, 0);
        cpu_addr = 12'h123;
        #1;
        chk("lr_addr_follow", imem_addr, 12'h123);
        send(8'h00);
        chk("lr_no_we_a", imem_we, 0);
        send(8'hF0);
        chk("lr_no_we_b", imem_we, 0);
        chk("lr_still_run", busy, 0);

        // RUN-state passthrough and ignored loader bytes
        cpu_addr = 12'h3A5;
        #1;
        chk("run_addr", imem_addr, 12'h3A5);
        rx_valid = 1'b1;
        rx_data  = 8'hAA;
        #1;
        chk("run_rx_ready", rx_ready, 0);
        step();
        chk("run_busy", busy, 0);
        chk("run_we", imem_we, 0);
        rx_valid = 1'b0;

        // load_req held across load_done, then a one-word load
        load_req = 1'b1;
        step();
        send(8'h00); send(8'h00);
        wait_release(held, wes);
        chk("lh_hold_cycles", held, 4);
        chk("lh_load_done", load_done, 1);
        chk("lh_run_busy", busy, 0);
        step();
        chk("lh_restart_busy", busy, 1);
        chk("lh_restart_ready", rx_ready, 1);
        load_req = 1'b0;
        send(8'h01); send(8'h00);
        send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
        chk("lh_w0_we", imem_we, 1);
        chk("lh_w0_addr", imem_addr, 12'h000);
        chk("lh_w0_data", imem_wdata, 32'hDEADBEEF);
        step();
        wait_release(held, wes);
        chk("lh_hold_cycles2", held, 4);
        chk("lh_words", words_loaded, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
